lut_neuron_loader: RTL

LUT_NEURON_LOADER -- requirements
Module: lut_neuron_loader

---
 rtl/lut_neuron_loader_pkg.sv | 20 ++
 rtl/lut_neuron_ram.sv | 31 +++
 rtl/lut_neuron_loader.sv | 119 +++++++++++
 3 files changed

// File: rtl/lut_neuron_loader_pkg.sv
`default_nettype none
// lut_neuron_loader_pkg: shared FSM state encoding and default sizes for the LUT neuron loader.
// ST_CHECK exists only when LUT_CHECKSUM_EN is defined.
package lut_neuron_loader_pkg;

  localparam int DEF_IN_BITS  = 4;
  localparam int DEF_OUT_BITS = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
`ifdef LUT_CHECKSUM_EN
    ,
    ST_CHECK = 2'd3
`endif
  } lut_state_t;

endpackage
`default_nettype wire

// File: rtl/lut_neuron_ram.sv
`default_nettype none
// lut_neuron_ram: distributed-style table, one write port, one registered read port.
// Only the read register is reset; the array contents survive reset.
module lut_neuron_ram #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [0:(2**ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Holds its last value between reads so the result stays stable while out_valid is low.
  always_ff @(posedge clk) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/lut_neuron_loader.sv
`default_nettype none
// lut_neuron_loader: streams a 2**IN_BITS-entry table in, then serves one lookup per cycle.
// Define LUT_CHECKSUM_EN to require a trailing XOR checksum beat before the table is usable.
module lut_neuron_loader
  import lut_neuron_loader_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                cfg_ready,
  output logic                loaded,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data,
  output logic                cfg_err
);

  localparam logic [IN_BITS:0] LAST_ADDR = (IN_BITS+1)'((2**IN_BITS) - 1);
  localparam logic [IN_BITS:0] ONE       = (IN_BITS+1)'(1);

  lut_state_t       state;
  logic [IN_BITS:0] count;
  logic             wr_en;
  logic             rd_en;

`ifdef LUT_CHECKSUM_EN
  logic [OUT_BITS-1:0] csum;
  logic                err_q;

  assign cfg_ready = (state == ST_LOAD) || (state == ST_CHECK);
  assign cfg_err   = err_q;
`else
  assign cfg_ready = (state == ST_LOAD);
  assign cfg_err   = 1'b0;
`endif

  // A start pulse wins over any concurrent load beat or lookup.
  assign in_ready = (state == ST_RUN) && !cfg_start;
  assign rd_en    = in_valid && in_ready;
  assign wr_en    = cfg_valid && (state == ST_LOAD) && !cfg_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      count     <= '0;
      loaded    <= 1'b0;
      out_valid <= 1'b0;
`ifdef LUT_CHECKSUM_EN
      csum      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      out_valid <= rd_en;
      if (cfg_start) begin
        state  <= ST_LOAD;
        count  <= '0;
        loaded <= 1'b0;
`ifdef LUT_CHECKSUM_EN
        csum   <= '0;
        err_q  <= 1'b0;
`endif
      end else begin
        case (state)
          ST_LOAD: begin
            if (cfg_valid) begin
              count <= count + ONE;
`ifdef LUT_CHECKSUM_EN
              csum  <= csum ^ cfg_data;
              if (count == LAST_ADDR) state <= ST_CHECK;
`else
              if (count == LAST_ADDR) begin
                state  <= ST_RUN;
                loaded <= 1'b1;
              end
`endif
            end
          end
`ifdef LUT_CHECKSUM_EN
          ST_CHECK: begin
            if (cfg_valid) begin
              if (cfg_data == csum) begin
                state  <= ST_RUN;
                loaded <= 1'b1;
              end else begin
                state <= ST_EMPTY;
                err_q <= 1'b1;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  lut_neuron_ram #(
    .ADDR_BITS (IN_BITS),
    .DATA_BITS (OUT_BITS)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (count[IN_BITS-1:0]),
    .wr_data (cfg_data),
    .rd_en   (rd_en),
    .rd_addr (in_data),
    .rd_data (out_data)
  );

endmodule
`default_nettype wire
